// File: rtl/amo_unit_pkg.sv
// amo_unit_pkg: atomic funct5 encodings, FSM states and memory size codes
package amo_unit_pkg;
  localparam logic [4:0] AMOADD  = 5'b00000;
  localparam logic [4:0] AMOSWAP = 5'b00001;
  localparam logic [4:0] LR      = 5'b00010;
  localparam logic [4:0] SC      = 5'b00011;
  localparam logic [4:0] AMOXOR  = 5'b00100;
  localparam logic [4:0] AMOOR   = 5'b01000;
  localparam logic [4:0] AMOAND  = 5'b01100;
  localparam logic [4:0] AMOMIN  = 5'b10000;
  localparam logic [4:0] AMOMAX  = 5'b10100;
  localparam logic [4:0] AMOMINU = 5'b11000;
  localparam logic [4:0] AMOMAXU = 5'b11100;
  localparam logic [1:0] SIZE_W  = 2'd2;
  localparam logic [1:0] SIZE_D  = 2'd3;
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
endpackage

// File: rtl/amo_alu.sv
// amo_alu: combinational read-modify-write function f(rs2, old) with 32-bit w mode
module amo_alu
  import amo_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      op,
  input  logic            w,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] old,
  output logic [XLEN-1:0] res
);
  logic [XLEN-1:0] a, b, r;
  logic lt, ltu;
  // sign-extending both operands in w mode keeps signed and unsigned order intact
  always_comb begin
    a   = w ? XLEN'($signed(rs2[31:0])) : rs2;
    b   = w ? XLEN'($signed(old[31:0])) : old;
    lt  = $signed(a) < $signed(b);
    ltu = a < b;
    r   = (op == AMOSWAP) ? a :
          (op == AMOXOR)  ? a ^ b :
          (op == AMOAND)  ? a & b :
          (op == AMOOR)   ? a | b :
          (op == AMOMIN)  ? (lt ? a : b) :
          (op == AMOMAX)  ? (lt ? b : a) :
          (op == AMOMINU) ? (ltu ? a : b) :
          (op == AMOMAXU) ? (ltu ? b : a) : a + b;
    res = w ? XLEN'($signed(r[31:0])) : r;
  end
endmodule

// File: rtl/amo_unit.sv
// amo_unit: sequential LR/SC/AMO engine with reservation tracking and memory handshake
module amo_unit
  import amo_unit_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int RESV_GRAN_LOG2 = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [4:0]      i_op,
  input  logic            i_w,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_done,
  output logic [XLEN-1:0] o_rd,
  output logic            o_misaligned,
  output logic            o_fault,
  output logic            mem_req,
  output logic            mem_we,
  output logic [1:0]      mem_size,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic            mem_err,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            i_snoop_valid,
  input  logic [XLEN-1:0] i_snoop_addr,
  input  logic            i_resv_clear
);
  localparam int G = RESV_GRAN_LOG2;
  state_t state, state_n;
  logic [4:0] op;
  logic w, w_in, mis_in, resv_valid, resv_hit, lr_set, snoop_hit, sc_clr;
  logic [XLEN-1:0] rs2, rdata_x, res;
  logic [XLEN-1:G] resv_addr;
  logic unused_snoop;
  assign unused_snoop = ^i_snoop_addr[G-1:0];
  assign o_ready = state == IDLE;
  assign o_done  = state == RESP;
  assign mem_req = state == RD || state == WR;
  assign mem_we  = state == WR;
  always_comb begin
    w_in      = XLEN == 32 || i_w;
    mis_in    = w_in ? |i_addr[1:0] : |i_addr[2:0];
    resv_hit  = resv_valid && resv_addr == i_addr[XLEN-1:G];
    rdata_x   = w ? XLEN'($signed(mem_rdata[31:0])) : mem_rdata;
    lr_set    = state == RD && mem_ack && !mem_err && op == LR;
    snoop_hit = i_snoop_valid && i_snoop_addr[XLEN-1:G] == (lr_set ? mem_addr[XLEN-1:G] : resv_addr);
    sc_clr    = (state == IDLE && i_valid && i_op == SC && (mis_in || !resv_hit)) ||
                (state == WR && mem_ack && op == SC);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !i_valid ? IDLE : (mis_in || (i_op == SC && !resv_hit)) ? RESP : (i_op == SC) ? WR : RD;
      RD:      state_n = !mem_ack ? RD : (mem_err || op == LR) ? RESP : WR;
      WR:      state_n = mem_ack ? RESP : WR;
      default: state_n = IDLE;
    endcase
  end
  amo_alu #(.XLEN(XLEN)) u_alu (.op(op), .w(w), .rs2(rs2), .old(rdata_x), .res(res));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op           <= AMOADD;
      w            <= 1'b1;
      rs2          <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_size     <= SIZE_W;
      o_rd         <= '0;
      o_misaligned <= 1'b0;
      o_fault      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          op           <= i_op;
          w            <= w_in;
          rs2          <= i_rs2;
          mem_addr     <= i_addr;
          mem_wdata    <= i_rs2;
          mem_size     <= w_in ? SIZE_W : SIZE_D;
          o_rd         <= XLEN'(!mis_in && i_op == SC && !resv_hit);
          o_misaligned <= mis_in;
          o_fault      <= 1'b0;
        end
        RD: if (mem_ack) begin
          o_rd      <= mem_err ? '0 : rdata_x;
          mem_wdata <= res;
          o_fault   <= mem_err;
        end
        WR: if (mem_ack) o_fault <= mem_err;
        default: ;
      endcase
    end
  end
  // a clear or snoop in the same cycle as an LR set wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resv_valid <= 1'b0;
      resv_addr  <= '0;
    end else begin
      if (lr_set) resv_addr <= mem_addr[XLEN-1:G];
      resv_valid <= (resv_valid || lr_set) && !i_resv_clear && !snoop_hit && !sc_clr;
    end
  end
endmodule
